// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, word
// width, default reset PC and a word-alignment helper.
package instruction_fetch_unit_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        DELIVER = 2'd3
    } fetch_state_e;

    // Clear the byte-offset bits so the result is a word address.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~(WORD_W'(3));
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: PC adder link, redirect, instruction-memory req/ack
// and decode valid/ready.
//   master : the fetch unit (drives PCResult, IMemReq/IMemAddr, Instr*)
//   slave  : surrounding datapath, memory and decode
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic [WORD_W-1:0] PCAddResult;
    logic [WORD_W-1:0] PCResult;
    logic              BranchTaken;
    logic [WORD_W-1:0] BranchTarget;
    logic              IMemReq;
    logic [WORD_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [WORD_W-1:0] IMemData;
    logic              InstrValid;
    logic [WORD_W-1:0] Instruction;
    logic [WORD_W-1:0] InstrPC;
    logic              InstrReady;

    modport master (
        input  PCAddResult, BranchTaken, BranchTarget, IMemAck, IMemData, InstrReady,
        output PCResult, IMemReq, IMemAddr, InstrValid, Instruction, InstrPC
    );

    modport slave (
        output PCAddResult, BranchTaken, BranchTarget, IMemAck, IMemData, InstrReady,
        input  PCResult, IMemReq, IMemAddr, InstrValid, Instruction, InstrPC
    );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches the word at PC via req/ack and
// hands it to decode via valid/ready. Redirects replace the PC; a redirect
// that arrives while a fetch is outstanding is parked until the ack so the
// stale data can be dropped.
// Ports:
//   Clk, Reset : clock and asynchronous active-high reset
//   bus        : fetch bus (master side), see instruction_fetch_unit_if
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                      Clk,
    input  logic                      Reset,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pending_q, pending_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] target_c;

    assign target_c = word_align(bus.BranchTarget);

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= word_align(RESET_PC);
            pending_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state, PC selection and capture; redirect outranks ack and ready
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            IDLE: begin
                if (bus.BranchTaken) begin
                    pc_d = target_c;
                end
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.BranchTaken) begin
                    if (bus.IMemAck) begin
                        pc_d    = target_c;
                        state_d = FETCH;
                    end else begin
                        // Request cannot be withdrawn: wait for its ack.
                        pending_d = target_c;
                        state_d   = DRAIN;
                    end
                end else if (bus.IMemAck) begin
                    instr_d    = bus.IMemData;
                    instr_pc_d = pc_q;
                    pc_d       = bus.PCAddResult;
                    state_d    = DELIVER;
                end
            end
            DRAIN: begin
                if (bus.IMemAck) begin
                    pc_d    = bus.BranchTaken ? target_c : pending_q;
                    state_d = FETCH;
                end else if (bus.BranchTaken) begin
                    pending_d = target_c;
                end
            end
            DELIVER: begin
                if (bus.BranchTaken) begin
                    pc_d    = target_c;
                    state_d = FETCH;
                end else if (bus.InstrReady) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        req_d   = (state_d == FETCH) || (state_d == DRAIN);
        valid_d = (state_d == DELIVER);
    end

    assign bus.PCResult    = pc_q;
    assign bus.IMemAddr    = pc_q;
    assign bus.IMemReq     = req_q;
    assign bus.InstrValid  = valid_q;
    assign bus.Instruction = instr_q;
    assign bus.InstrPC     = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by a randomized run, all compared against a transaction-level model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_KEY     = 32'hA5A5_A5A5;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // External PC+4 adder
    assign bus.PCAddResult = bus.PCResult + 32'd4;

    initial forever #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the outputs should look like after the next edge
    logic [31:0] m_pc, m_instr, m_ipc, m_owed_tgt;
    bit          m_started, m_req, m_valid, m_owed;

    // Memory responder: ack after mem_wait idle request cycles
    int mem_wait = 0;
    int mem_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = TB_RESET_PC;
        m_instr   = '0;
        m_ipc     = '0;
        m_owed_tgt = '0;
        m_started = 1'b0;
        m_req     = 1'b0;
        m_valid   = 1'b0;
        m_owed    = 1'b0;
        mem_cnt   = 0;
    endtask

    task automatic check_all();
        chk("pc",    bus.PCResult,            m_pc);
        chk("addr",  bus.IMemAddr,            m_pc);
        chk("req",   {31'b0, bus.IMemReq},    {31'b0, m_req});
        chk("valid", {31'b0, bus.InstrValid}, {31'b0, m_valid});
        chk("instr", bus.Instruction,         m_instr);
        chk("ipc",   bus.InstrPC,             m_ipc);
    endtask

    // Drive inputs for the coming edge and advance the model across it
    task automatic drive_and_model(input bit br, input logic [31:0] tgt, input bit rdy);
        bit          ack;
        logic [31:0] t;
        ack = 1'b0;
        if (m_req) begin
            if (mem_cnt >= mem_wait) begin
                ack     = 1'b1;
                mem_cnt = 0;
            end else begin
                mem_cnt++;
            end
        end
        bus.IMemAck      = ack;
        bus.IMemData     = ack ? (m_pc ^ XOR_KEY) : $urandom();
        bus.BranchTaken  = br;
        bus.BranchTarget = tgt;
        bus.InstrReady   = rdy;
        t = {tgt[31:2], 2'b00};

        if (!m_started) begin
            m_started = 1'b1;
            if (br) m_pc = t;
            m_req = 1'b1;
        end else if (m_valid) begin
            if (br) begin
                m_pc = t; m_valid = 1'b0; m_req = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0; m_req = 1'b1;
            end
        end else if (m_req) begin
            if (m_owed) begin
                if (ack) begin
                    m_pc   = br ? t : m_owed_tgt;
                    m_owed = 1'b0;
                end else if (br) begin
                    m_owed_tgt = t;
                end
            end else if (br) begin
                if (ack) begin
                    m_pc = t;
                end else begin
                    m_owed = 1'b1; m_owed_tgt = t;
                end
            end else if (ack) begin
                m_instr = m_pc ^ XOR_KEY;
                m_ipc   = m_pc;
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b1;
                m_req   = 1'b0;
            end
        end
    endtask

    task automatic step(input bit br, input logic [31:0] tgt, input bit rdy);
        @(negedge Clk);
        check_all();
        drive_and_model(br, tgt, rdy);
    endtask

    task automatic idle_inputs();
        bus.IMemAck      = 1'b0;
        bus.IMemData     = '0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = '0;
        bus.InstrReady   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge Clk);
        check_all();
        Reset = 1'b0;
        drive_and_model(1'b0, '0, 1'b1);
    endtask

    // Assert reset between edges and confirm outputs fall without a clock
    task automatic async_reset(input string tag);
        @(negedge Clk);
        check_all();
        #2 Reset = 1'b1;
        #1;
        chk({tag, "_req"},   {31'b0, bus.IMemReq},    32'd0);
        chk({tag, "_valid"}, {31'b0, bus.InstrValid}, 32'd0);
        chk({tag, "_pc"},    bus.PCResult,            TB_RESET_PC);
        idle_inputs();
        model_reset();
        @(negedge Clk);
        check_all();
        Reset = 1'b0;
        drive_and_model(1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [31:0] ipcs[$];
        logic [5:0]  hist;
        int          req_cycles, last_req_i, valid_i, valid_seen;
        bit          br, rdy;
        logic [31:0] tgt;

        idle_inputs();
        model_reset();

        // Zero-wait memory, decode always ready
        do_reset();
        mem_wait = 0;
        hist = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1);
            hist = {hist[4:0], bus.InstrValid};
            if (bus.InstrValid) ipcs.push_back(bus.InstrPC);
        end
        chk("t1_valid_pattern", {26'b0, hist}, 32'b010101);
        chk("t1_count", 32'(ipcs.size()), 32'd3);
        for (int i = 0; i < ipcs.size() && i < 3; i++)
            chk("t1_ipc_seq", ipcs[i], 32'(4 * i));

        // Three wait cycles, then decode stalls
        mem_wait   = 3;
        req_cycles = 0;
        last_req_i = -1;
        valid_i    = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b0);
            if (bus.IMemReq) begin
                req_cycles++;
                last_req_i = i;
                chk("t2_addr_stable", bus.IMemAddr, 32'd12);
            end
            if (bus.InstrValid) begin
                valid_i = i;
                break;
            end
        end
        chk("t2_req_cycles", 32'(req_cycles), 32'd4);
        chk("t2_valid_lag", 32'(valid_i - last_req_i), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0);
            chk("t3_valid_hold", {31'b0, bus.InstrValid}, 32'd1);
            chk("t3_no_req",     {31'b0, bus.IMemReq},    32'd0);
            chk("t3_ipc_hold",   bus.InstrPC,             32'd12);
            chk("t3_instr_hold", bus.Instruction,         32'd12 ^ XOR_KEY);
        end

        // Redirect while delivering, unaligned target
        step(1'b1, 32'h0000_0103, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("t4_valid_drop", {31'b0, bus.InstrValid}, 32'd0);
        chk("t4_req",        {31'b0, bus.IMemReq},    32'd1);
        chk("t4_addr",       bus.IMemAddr,            32'h0000_0100);

        // Two redirects during a 4-wait fetch at 8
        do_reset();
        mem_wait = 0;
        for (int i = 0; i < 20 && !(m_req && m_pc == 32'd8 && !m_valid); i++)
            step(1'b0, '0, 1'b1);
        mem_wait   = 4;
        valid_seen = 0;
        step(1'b0, '0, 1'b1);          valid_seen += int'(bus.InstrValid);
        step(1'b1, 32'h0000_0040, 1'b1); valid_seen += int'(bus.InstrValid);
        step(1'b1, 32'h0000_0080, 1'b1); valid_seen += int'(bus.InstrValid);
        step(1'b0, '0, 1'b1);          valid_seen += int'(bus.InstrValid);
        step(1'b0, '0, 1'b1);          valid_seen += int'(bus.InstrValid);
        mem_wait = 0;
        step(1'b0, '0, 1'b1);
        chk("t5_no_valid", 32'(valid_seen), 32'd0);
        chk("t5_valid",    {31'b0, bus.InstrValid}, 32'd0);
        chk("t5_req",      {31'b0, bus.IMemReq},    32'd1);
        chk("t5_addr",     bus.IMemAddr,            32'h0000_0080);

        // PC wrap through the adder
        step(1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("wrap_ipc",   bus.InstrPC,     32'hFFFF_FFFC);
        chk("wrap_instr", bus.Instruction, 32'hFFFF_FFFC ^ XOR_KEY);
        chk("wrap_pc",    bus.PCResult,    32'h0000_0000);

        // Asynchronous reset while delivering, then while fetching
        chk("t6_pre_valid", {31'b0, bus.InstrValid}, 32'd1);
        async_reset("t6_deliver");
        mem_wait = 5;
        step(1'b0, '0, 1'b1);
        chk("t6_pre_req", {31'b0, bus.IMemReq}, 32'd1);
        async_reset("t6_fetch");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (mem_cnt == 0) mem_wait = int'($urandom_range(0, 3));
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                              : 32'($urandom());
            if ($urandom_range(0, 299) == 0) async_reset("rand_reset");
            else step(br, tgt, rdy);
        end
        @(negedge Clk);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Owns the program counter register and sequences instruction fetches from instruction memory. It drives `PCResult` into the existing PC+4 adder and consumes `PCAddResult` from it. It fetches the word at the current PC through a req/ack handshake and presents it to decode with a valid/ready handshake. Taken branches and jumps redirect the PC, and any in-flight fetch is discarded safely.

## Interface
Parameters:
- `RESET_PC`, default `32'h00000000`: PC value loaded on reset. Bits [1:0] must be 0.

Ports:
- `Clk`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `PCAddResult`  in  32: PC+4 from the adder, which is driven by `PCResult`.
- `PCResult`  out  32: current PC register.
- `BranchTaken`  in  1: redirect request, single-cycle pulse or level.
- `BranchTarget`  in  32: redirect address. Bits [1:0] are ignored and forced to 0.
- `IMemReq`  out  1: fetch request.
- `IMemAddr`  out  32: fetch address. Always equals `PCResult`.
- `IMemAck`  in  1: memory has returned data this cycle.
- `IMemData`  in  32: instruction word, valid when `IMemAck` is high.
- `InstrValid`  out  1: `Instruction` and `InstrPC` are valid.
- `Instruction`  out  32: fetched word.
- `InstrPC`  out  32: address `Instruction` was fetched from.
- `InstrReady`  in  1: decode accepts this cycle.

## Operation
- State machine `IDLE`, `FETCH`, `DRAIN`, `DELIVER`. Reset state is `IDLE`.
- Reset values: `PCResult` = `RESET_PC`; `IMemReq`, `InstrValid` = 0; `Instruction`, `InstrPC` = 0; pending target = 0.
- `IDLE` -> `FETCH` unconditionally on the first edge after reset release.
- `FETCH`: `IMemReq` is high and the address is held stable.
  - On `IMemAck` without redirect: capture `Instruction` = `IMemData` and `InstrPC` = `PCResult`; load `PCResult` <= `PCAddResult`; go to `DELIVER`.
- `DELIVER`: `InstrValid` is high and `IMemReq` is low.
  - On `InstrReady`: go to `FETCH`.
  - `Instruction` and `InstrPC` must not change while `InstrValid` is high and `InstrReady` is low.
- Redirect priority: `BranchTaken` beats `IMemAck` and `InstrReady`.
  - In `IDLE` or `DELIVER`: `PCResult` <= target, `InstrValid` <= 0, go to `FETCH`.
  - In `FETCH` together with `IMemAck`: data is discarded, `PCResult` <= target, go to `FETCH`.
  - In `FETCH` without `IMemAck`: the request cannot be withdrawn. Latch the target into a pending register and go to `DRAIN`.
- `DRAIN`: `IMemReq` stays high at the old `PCResult`.
  - A further `BranchTaken` overwrites the pending target; the newest target wins.
  - On `IMemAck`: discard data, `PCResult` <= latest target (a same-cycle `BranchTarget` takes precedence), go to `FETCH`.
  - `InstrValid` is never asserted from `DRAIN`.
- Arithmetic: the unit itself performs no addition. PC+4 comes only from `PCAddResult`; the 32-bit wrap from `32'hFFFFFFFC` to `0` is inherited from the adder.
- Reset mid-operation: all registers return to their reset values immediately, asynchronously. Any outstanding memory request is abandoned; memory must tolerate `IMemReq` falling.

## Timing
- `IMemReq` first rises in the 2nd cycle after `Reset` deasserts (`IDLE` occupies 1 cycle).
- `IMemAck` may arrive in the first cycle `IMemReq` is high (zero wait), or after any number of wait cycles.
- Ack in cycle N -> `InstrValid` high and `PCResult` updated in cycle N+1.
- `InstrReady` in cycle M with valid high -> `InstrValid` low and `IMemReq` high in cycle M+1.
- Best-case throughput: one instruction per 2 cycles with zero-wait memory and always-ready decode.
- Redirect in cycle R (not `DRAIN`-bound) -> `PCResult` = target and `IMemReq` high by cycle R+1.
- All outputs are registered except `IMemAddr`, which is wired to `PCResult`.

## Structure
- Shared package holds:
  - state encoding (2-bit `IDLE`=0, `FETCH`=1, `DRAIN`=2, `DELIVER`=3);
  - the 32-bit word-width constant;
  - the default reset-PC constant.
- Single module; no sub-module. The PC+4 adder is instantiated alongside it in the parent datapath, not inside.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning `addr^32'hA5A5A5A5`; decode always ready -> `InstrPC` sequence 0, 4, 8, and `InstrValid` pulses every 2nd cycle.
- Memory with 3 wait cycles -> `IMemReq` held 4 cycles at a stable address; `InstrValid` rises exactly 1 cycle after ack.
- Decode stalls `InstrReady` low for 5 cycles -> `Instruction` and `InstrPC` remain stable, with no new `IMemReq`.
- `BranchTaken` to `32'h00000103` in `DELIVER` -> valid drops next cycle and the next fetch address is `32'h00000100`.
- `BranchTaken` to `0x40` in wait cycle 1 of a 4-wait fetch at 8, then to `0x80` one cycle later -> the ack data is discarded, no `InstrValid`, and the next `IMemAddr` is `0x80`.
- `Reset` asserted while `IMemReq` is high and `InstrValid` is high -> both drop asynchronously; `PCResult` returns to `RESET_PC`.
